// File: rtl/dht11_pkg.sv
// Shared definitions for the DHT11 responder: FSM encoding, phase lengths
// in ticks, and the frame checksum helper.
package dht11_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_DET_LOW   = 3'd1,
    S_WAIT_HOST = 3'd2,
    S_ACK_LOW   = 3'd3,
    S_ACK_HIGH  = 3'd4,
    S_BIT_LOW   = 3'd5,
    S_BIT_HIGH  = 3'd6,
    S_END_LOW   = 3'd7
  } state_t;

  localparam int ACK_TICKS       = 8;
  localparam int BIT_LOW_TICKS   = 5;
  localparam int ZERO_HIGH_TICKS = 3;
  localparam int ONE_HIGH_TICKS  = 7;
  localparam int END_TICKS       = 5;
  localparam int FRAME_BITS      = 40;

  // 8-bit wrap-around sum of the four data bytes; corrupt flips the LSB.
  function automatic logic [7:0] frame_checksum(input logic [7:0] a,
                                                input logic [7:0] b,
                                                input logic [7:0] c,
                                                input logic [7:0] d,
                                                input logic       corrupt);
    logic [7:0] s;
    s = a + b + c + d;
    return s ^ {7'b0, corrupt};
  endfunction

endpackage

// File: rtl/dht11_tick_sync.sv
// Tick prescaler: one-cycle tick every F_COUNT cycles. A clear restarts the
// count so the next tick lands exactly F_COUNT cycles later.
module dht11_tick_sync #(
  parameter int F_COUNT = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CW = (F_COUNT > 1) ? $clog2(F_COUNT) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(F_COUNT - 1));

  // Free-running modulo-F_COUNT counter with synchronous clear.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dht11_responder.sv
// DHT11 sensor emulator. Detects a long host start low on the open-drain
// line, then answers with the ACK preamble and a 40-bit MSB-first frame
// {rh_int, rh_dec, t_int, t_dec, checksum}. The line is only ever pulled low.
// state_dbg mirrors the FSM state for observation.
module dht11_responder
  import dht11_pkg::*;
#(
  parameter int F_COUNT          = 1000,
  parameter int MIN_START_TICKS  = 1800,
  parameter int RESP_DELAY_TICKS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rh_int,
  input  logic [7:0] rh_dec,
  input  logic [7:0] t_int,
  input  logic [7:0] t_dec,
  input  logic       corrupt_checksum,
  output logic       busy,
  output logic       frame_done,
  output logic [2:0] state_dbg,
  inout  wire        dht11_io
);

  state_t      state;
  logic [1:0]  sync;
  logic        line_s;
  logic        drv_low;
  logic [15:0] tcnt;
  logic [5:0]  bcnt;
  logic [39:0] shreg;
  logic        tick;
  logic        leave;
  logic        timed;
  logic [15:0] phase_ticks;

  assign dht11_io  = drv_low ? 1'b0 : 1'bz;
  assign line_s    = sync[1];
  assign state_dbg = state;

  // The prescaler restarts on every state change so phases are exact.
  dht11_tick_sync #(.F_COUNT(F_COUNT)) u_tick (
    .clk   (clk),
    .rst   (rst),
    .clear (leave),
    .tick  (tick)
  );

  // Two-flop synchronizer; resets to the idle (pulled-up) level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= 2'b11;
    end else begin
      sync <= {sync[0], dht11_io};
    end
  end

  // Phase length of the current state and whether it ends this cycle.
  always_comb begin
    phase_ticks = 16'd0;
    timed       = 1'b1;
    leave       = 1'b0;
    case (state)
      S_WAIT_HOST:          phase_ticks = 16'(RESP_DELAY_TICKS);
      S_ACK_LOW, S_ACK_HIGH: phase_ticks = 16'(ACK_TICKS);
      S_BIT_LOW:            phase_ticks = 16'(BIT_LOW_TICKS);
      S_BIT_HIGH:           phase_ticks = shreg[39] ? 16'(ONE_HIGH_TICKS)
                                                    : 16'(ZERO_HIGH_TICKS);
      S_END_LOW:            phase_ticks = 16'(END_TICKS);
      default:              timed = 1'b0;
    endcase
    if (timed) begin
      leave = tick && (tcnt == phase_ticks - 16'd1);
    end else if (state == S_IDLE) begin
      leave = !line_s;
    end else begin
      leave = line_s;
    end
  end

  // Main FSM with registered line drive, busy and frame_done.
  // Leaving END_LOW the synchronizer still shows our own low for two cycles,
  // which enters DET_LOW briefly and falls back to IDLE as a short pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      drv_low    <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      shreg      <= '0;
      tcnt       <= '0;
      bcnt       <= '0;
    end else begin
      frame_done <= 1'b0;
      if (leave) begin
        tcnt <= '0;
      end else if (tick && (tcnt != '1)) begin
        tcnt <= tcnt + 16'd1;
      end
      if (leave) begin
        case (state)
          S_IDLE: state <= S_DET_LOW;
          S_DET_LOW: begin
            state <= (tcnt >= 16'(MIN_START_TICKS)) ? S_WAIT_HOST : S_IDLE;
          end
          S_WAIT_HOST: begin
            state   <= S_ACK_LOW;
            shreg   <= {rh_int, rh_dec, t_int, t_dec,
                        frame_checksum(rh_int, rh_dec, t_int, t_dec,
                                       corrupt_checksum)};
            bcnt    <= '0;
            drv_low <= 1'b1;
            busy    <= 1'b1;
          end
          S_ACK_LOW: begin
            state   <= S_ACK_HIGH;
            drv_low <= 1'b0;
          end
          S_ACK_HIGH: begin
            state   <= S_BIT_LOW;
            drv_low <= 1'b1;
          end
          S_BIT_LOW: begin
            state   <= S_BIT_HIGH;
            drv_low <= 1'b0;
          end
          S_BIT_HIGH: begin
            shreg   <= {shreg[38:0], 1'b0};
            bcnt    <= bcnt + 6'd1;
            drv_low <= 1'b1;
            state   <= (bcnt == 6'(FRAME_BITS - 1)) ? S_END_LOW : S_BIT_LOW;
          end
          S_END_LOW: begin
            state      <= S_IDLE;
            drv_low    <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b1;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dht11_responder.sv
// Bench for dht11_responder: a host drives start pulses, a waveform model
// built from the protocol rules predicts {line, busy, frame_done} every
// cycle, and a line decoder recovers the 40 bits for literal checks.
module tb_dht11_responder;
  import dht11_pkg::*;

  localparam int F    = 4;
  localparam int MINT = 20;
  localparam int RESP = 4;

  // Clock and reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0] rh_int = 8'h00, rh_dec = 8'h00, t_int = 8'h00, t_dec = 8'h00;
  logic       corrupt_checksum = 1'b0;
  logic       busy, frame_done;
  logic [2:0] state_dbg;
  logic       host_low = 1'b0;
  wire        dht11_io;

  pullup (dht11_io);
  assign dht11_io = host_low ? 1'b0 : 1'bz;

  dht11_responder #(
    .F_COUNT          (F),
    .MIN_START_TICKS  (MINT),
    .RESP_DELAY_TICKS (RESP)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .rh_int           (rh_int),
    .rh_dec           (rh_dec),
    .t_int            (t_int),
    .t_dec            (t_dec),
    .corrupt_checksum (corrupt_checksum),
    .busy             (busy),
    .frame_done       (frame_done),
    .state_dbg        (state_dbg),
    .dht11_io         (dht11_io)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic chk_en = 1'b0;

  // Expected {line, busy, frame_done} per sampled cycle
  logic [2:0] exp_q[$];
  logic [2:0] act_v, req_v;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Scoreboard: per-cycle compare against the model waveform; outside a
  // frame the line must follow the host and busy/frame_done stay low.
  always @(negedge clk) begin
    cyc++;
    if (chk_en) begin
      act_v = {(dht11_io === 1'b1), busy, frame_done};
      if (exp_q.size() > 0) req_v = exp_q.pop_front();
      else                  req_v = {~host_low, 2'b00};
      total++;
      if (act_v !== req_v) begin
        bad++;
        $display("FAIL cycle_io at %0d actual=%b required=%b", cyc, act_v, req_v);
      end
    end
  end

  // Line decoder: high runs after the ACK high are data bits.
  int          dec_runs = 0;
  int          dec_hi   = 0;
  int          dec_nb   = 0;
  logic [39:0] dec_bits = '0;
  logic        dec_prev = 1'b1;
  int          fd_cnt   = 0;
  always @(negedge clk) begin
    if (frame_done === 1'b1) fd_cnt <= fd_cnt + 1;
    if (host_low) begin
      dec_runs <= 0;
      dec_hi   <= 0;
      dec_nb   <= 0;
      dec_bits <= '0;
    end else if (dht11_io === 1'b1) begin
      dec_hi <= dec_hi + 1;
    end else begin
      dec_hi <= 0;
      if (dec_prev) begin
        dec_runs <= dec_runs + 1;
        if (dec_runs >= 2) begin
          dec_bits <= {dec_bits[38:0], (dec_hi >= 5 * F)};
          dec_nb   <= dec_nb + 1;
        end
      end
    end
    dec_prev <= (dht11_io === 1'b1);
  end

  // Model: frame contents from the data bytes
  function automatic logic [39:0] build_frame(input int a, input int b,
                                              input int c, input int d,
                                              input bit corr);
    int s;
    s = (a + b + c + d) % 256;
    if (corr) s = s ^ 1;
    return {a[7:0], b[7:0], c[7:0], d[7:0], s[7:0]};
  endfunction

  task automatic push_n(input int n, input logic [2:0] v);
    for (int i = 0; i < n; i++) exp_q.push_back(v);
  endtask

  // Model: waveform from the host release (3 sync/FSM cycles + response delay)
  task automatic push_expect(input logic [39:0] fr);
    push_n(3 + RESP * F, 3'b100);
    push_n(8 * F, 3'b010);
    push_n(8 * F, 3'b110);
    for (int b = 39; b >= 0; b--) begin
      push_n(5 * F, 3'b010);
      push_n((fr[b] ? 7 : 3) * F, 3'b110);
    end
    push_n(5 * F, 3'b010);
    exp_q.push_back(3'b101);
  endtask

  // Driver: host start pulse of the given length in cycles
  task automatic host_start(input int low_cycles);
    @(posedge clk) #1 host_low = 1'b1;
    repeat (low_cycles) @(posedge clk);
    #1 host_low = 1'b0;
  endtask

  task automatic send_frame(input int a, input int b, input int c,
                            input int d, input bit corr);
    rh_int = a[7:0]; rh_dec = b[7:0]; t_int = c[7:0]; t_dec = d[7:0];
    corrupt_checksum = corr;
    host_start((MINT + 2) * F);
    push_expect(build_frame(a, b, c, d, corr));
  endtask

  task automatic wait_frame(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 6000) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      check({name, "_timeout"}, 64'(exp_q.size()), 64'd0);
      exp_q.delete();
    end
    repeat (6) @(posedge clk);
    #1;
  endtask

  int fd0;

  initial begin
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_state", 64'(state_dbg), 64'(S_IDLE));
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_frame_done", 64'(frame_done), 64'd0);
    check("rst_line", 64'(dht11_io === 1'b1), 64'd1);
    chk_en = 1'b1;

    // Basic frame
    fd0 = fd_cnt;
    send_frame(8'h2D, 8'h00, 8'h19, 8'h00, 1'b0);
    wait_frame("frame_a");
    check("frame_a_bits", 64'(dec_bits), 64'h2D00190046);
    check("frame_a_nbits", 64'(dec_nb), 64'd40);
    check("frame_a_done_cnt", 64'(fd_cnt - fd0), 64'd1);

    // Short host pulse is ignored
    host_start(5 * F);
    repeat (30) @(posedge clk);
    #1;
    check("short_state", 64'(state_dbg), 64'(S_IDLE));
    check("short_busy", 64'(busy), 64'd0);

    // Checksum wrap-around and error injection
    send_frame(8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b0);
    wait_frame("frame_ff");
    check("frame_ff_bits", 64'(dec_bits), 64'hFFFFFFFFFC);
    send_frame(8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b1);
    wait_frame("frame_ff_corrupt");
    check("frame_ff_corrupt_bits", 64'(dec_bits), 64'hFFFFFFFFFD);
    corrupt_checksum = 1'b0;

    // Input change during ACK_HIGH does not reach the frame in flight
    send_frame(8'h2D, 8'h00, 8'h19, 8'h00, 1'b0);
    repeat (3 + 4 * F + 8 * F + 2 * F) @(posedge clk);
    #1 t_int = 8'h20;
    wait_frame("frame_snap");
    check("frame_snap_bits", 64'(dec_bits), 64'h2D00190046);

    // Reset during bit 12 abandons the frame
    fd0 = fd_cnt;
    send_frame(8'h2D, 8'h00, 8'h19, 8'h00, 1'b0);
    begin
      int n;
      n = 0;
      while (dec_nb < 12 && n < 3000) begin
        @(negedge clk);
        n++;
      end
      check("bit12_reached", 64'(dec_nb >= 12), 64'd1);
    end
    @(posedge clk) #1 rst = 1'b1;
    @(posedge clk) #1 rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("midrst_line", 64'(dht11_io === 1'b1), 64'd1);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_state", 64'(state_dbg), 64'(S_IDLE));
    repeat (100) @(posedge clk);
    #1;
    check("midrst_no_done", 64'(fd_cnt - fd0), 64'd0);

    // Fresh start after reset completes a frame
    fd0 = fd_cnt;
    send_frame(8'h01, 8'h02, 8'h03, 8'h04, 1'b0);
    wait_frame("frame_after_rst");
    check("frame_after_rst_bits", 64'(dec_bits), 64'h010203040A);
    check("frame_after_rst_done", 64'(fd_cnt - fd0), 64'd1);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dht11_responder.md
# dht11_responder

Single-wire DHT11 sensor emulator: the responder end of the DHT11 protocol that our `dht11_controller` initiates. It watches the shared `dht11_io` line for a host start pulse, then answers with the ACK preamble and a 40-bit frame built from its data inputs, including the checksum. It sits on a spare Pmod pin for board-level loopback against `dht11_controller`, and it stands in for the real sensor in the system testbench.

## Interface
- `F_COUNT`, 1000: clock cycles per 10 µs tick (100 MHz clock).
- `MIN_START_TICKS`, 1800: minimum host low time, in ticks (18 ms), accepted as a start.
- `RESP_DELAY_TICKS`, 4: ticks from the host's rising edge to the responder's first drive-low.
- `clk`  in  1  system clock.
- `rst`  in  1  reset, synchronous, active-high.
- `rh_int`  in  8  humidity, integer byte.
- `rh_dec`  in  8  humidity, decimal byte.
- `t_int`  in  8  temperature, integer byte.
- `t_dec`  in  8  temperature, decimal byte.
- `corrupt_checksum`  in  1  when high, the checksum LSB is inverted (error injection).
- `busy`  out  1  high from ACK_LOW through END_LOW.
- `frame_done`  out  1  one-cycle pulse when END_LOW completes.
- `dht11_io`  inout  1  open-drain line: the block drives 0 or `z`, never 1. A board PULLUP or bench `pullup` is mandatory.

## Operation
- `dht11_io` is sampled through a 2-FF synchronizer. All decisions use the synchronized value.
- Output enable `drv_low` is registered: `dht11_io = drv_low ? 1'b0 : 1'bz`.
- The tick prescaler clears on every state transition, so each phase lasts an exact multiple of `F_COUNT` cycles.
- States and transitions:
  - **IDLE**: line released. A synchronized 0 moves to DET_LOW with `tcnt=0`.
  - **DET_LOW**: counts ticks while the line is low.
    - Line 1 with `tcnt < MIN_START_TICKS` returns to IDLE (glitch or short pulse).
    - Line 1 with `tcnt >= MIN_START_TICKS` moves to WAIT_HOST.
  - **WAIT_HOST**: waits `RESP_DELAY_TICKS` ticks, then goes to ACK_LOW.
    - On entry to ACK_LOW: snapshot `{rh_int, rh_dec, t_int, t_dec, cs}` into a 40-bit shift register, set `bcnt=0`, set `drv_low=1`.
  - **ACK_LOW**: 8 ticks driven low, then ACK_HIGH (released).
  - **ACK_HIGH**: 8 ticks released, then BIT_LOW.
  - **BIT_LOW**: 5 ticks driven low, then BIT_HIGH.
  - **BIT_HIGH**: released for 3 ticks if the shift register MSB is 0, or 7 ticks if it is 1.
    - Then shift left by 1 and increment `bcnt`.
    - Go to END_LOW if `bcnt == 39`, else BIT_LOW.
  - **END_LOW**: 5 ticks driven low, then release, pulse `frame_done`, and go to IDLE.
- Checksum: `cs = (rh_int + rh_dec + t_int + t_dec) mod 256`, computed in 8-bit wrap-around arithmetic, then XORed with `{7'b0, corrupt_checksum}`.
- Bits are sent MSB first: byte order rh_int, rh_dec, t_int, t_dec, cs.
- Input changes after the snapshot do not affect the frame in flight.
- Line activity during ACK_LOW through END_LOW is ignored; there is no collision detection.
- A new start low is recognised only from IDLE.

## Timing
- Reset values: state IDLE, `drv_low=0` (line released), `busy=0`, `frame_done=0`, shift register 0, `tcnt=0`, `bcnt=0`.
- `rst` asserted mid-frame releases the line on the next clock edge, and the frame is abandoned.
- Start detection latency: 2 cycles of synchronizer delay plus 1 cycle of FSM delay after the line edge.
- Phase durations in ticks: ACK 8+8; each bit 5+3 (value 0) or 5+7 (value 1); END 5.
- Frame length: 16 + Σ(bit durations) + 5 ticks. Example: an all-zero frame is 16 + 40·8 + 5 = 341 ticks = 3.41 ms.
- `busy` rises in the same cycle `drv_low` first rises. It falls in the same cycle as the `frame_done` pulse.
- Receiver margin: the host decodes a bit as 0 when the high time is under 5 ticks. 3 and 7 ticks straddle that threshold with ±2 ticks of margin.

## Structure
- Shared package `dht11_pkg`:
  - state encoding enum;
  - tick constants `ACK_TICKS=8`, `BIT_LOW_TICKS=5`, `ZERO_HIGH_TICKS=3`, `ONE_HIGH_TICKS=7`, `END_TICKS=5`, `FRAME_BITS=40`.
- Sub-module `dht11_tick_sync`: a `F_COUNT` prescaler with synchronous reset and a synchronous `clear` input. It emits a one-cycle `tick`.
- The synchronizer, FSM, counters and shift register live in the top level.

## Test plan
- rh_int=0x2D, rh_dec=0x00, t_int=0x19, t_dec=0x00; host low 19 ms, then release → first drive-low 40 µs after the rising edge; 40 bits decode to 0x2D_00_19_00_46; `frame_done` pulses once.
- Loopback with `dht11_controller`, same data → `rh_data=0x2D`, `t_data=0x19`, `dht11_valid=1`.
- Host low pulse of 5 ms → no drive-low, `busy` stays 0, state returns to IDLE.
- Inputs 0xFF,0xFF,0xFF,0xFF → cs=0xFC (wrap-around); with `corrupt_checksum=1`, cs=0xFD and the controller reports `dht11_valid=0`.
- Change `t_int` from 0x19 to 0x20 during ACK_HIGH → transmitted byte is still 0x19.
- Assert `rst` during bit 12 → `dht11_io` is `z` the next cycle, `busy=0`, no `frame_done`; a following valid start produces a complete frame.
